// File: rtl/alu_seq_if.sv
// ============================================================================
// Module      : alu_seq_if
// Description : Issue/result bundle for alu_seq (operands, instruction, result).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_if #(
    parameter int XLEN = 8
);
    logic            in_valid;
    logic            out_ready;
    logic [XLEN-1:0] in_r1;
    logic [XLEN-1:0] in_r2;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] out;
    logic            out_valid;
    logic            out_illegal;

    modport master (
        output in_valid, in_r1, in_r2, in_inst,
        input  out_ready, out, out_valid, out_illegal
    );

    modport slave (
        input  in_valid, in_r1, in_r2, in_inst,
        output out_ready, out, out_valid, out_illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle RV32I ALU (R/I-type) at width XLEN; iterative
//               shifts, optional shift-add MUL enabled by macro ALU_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int XLEN = 8
) (
    input  wire logic  in_clk,
    input  wire logic  in_rst_n,
    alu_seq_if.slave   bus
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_out;
    logic            r_illegal;
    logic            r_left;
    logic            r_arith;
`ifdef ALU_MUL_EN
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] w_mul_sum;
`endif

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [11:0]     w_imm12;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [SHW-1:0]  w_shamt;
    logic            w_rtype;
    logic            w_itype;
    logic            w_legal;
    logic            w_is_shift;
    logic            w_is_mul;
    logic            w_accept;
    logic            w_ready;
    logic [XLEN-1:0] w_res;
    logic [XLEN-1:0] w_shift_step;
    logic            w_unused;

    assign w_opcode = bus.in_inst[6:0];
    assign w_funct3 = bus.in_inst[14:12];
    assign w_funct7 = bus.in_inst[31:25];
    assign w_imm12  = bus.in_inst[31:20];
    assign w_rtype  = (w_opcode == 7'b0110011);
    assign w_itype  = (w_opcode == 7'b0010011);
    assign w_a      = bus.in_r1;
    assign w_b      = w_rtype ? bus.in_r2 : w_imm;
    assign w_shamt  = w_b[SHW-1:0];
    assign w_unused = ^{bus.in_inst[19:7], w_imm12};

    generate
        if (XLEN > 12) begin : g_imm_sext
            assign w_imm = {{(XLEN-12){w_imm12[11]}}, w_imm12};
        end else begin : g_imm_trunc
            assign w_imm = w_imm12[XLEN-1:0];
        end
    endgenerate

    // Legality and operation class; funct7 0100000 is only SUB/SRA/SRAI.
    always_comb begin
        w_legal  = 1'b0;
        w_is_mul = 1'b0;
        if (w_rtype) begin
            if (w_funct7 == 7'b0000000) begin
                w_legal = 1'b1;
            end else if (w_funct7 == 7'b0100000) begin
                w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
            end
`ifdef ALU_MUL_EN
            else if ((w_funct7 == 7'b0000001) && (w_funct3 == 3'b000)) begin
                w_legal  = 1'b1;
                w_is_mul = 1'b1;
            end
`endif
        end else if (w_itype) begin
            case (w_funct3)
                3'b001:  w_legal = (w_funct7 == 7'b0000000);
                3'b101:  w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                default: w_legal = 1'b1;
            endcase
        end
        w_is_shift = w_legal && !w_is_mul && ((w_funct3 == 3'b001) || (w_funct3 == 3'b101));
    end

    // Single-cycle result; shifts fall through to the operand for shamt = 0.
    always_comb begin
        w_res = w_a;
        case (w_funct3)
            3'b000:  w_res = (w_rtype && w_funct7[5]) ? (w_a - w_b) : (w_a + w_b);
            3'b010:  w_res = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            3'b011:  w_res = {{(XLEN-1){1'b0}}, (w_a < w_b)};
            3'b100:  w_res = w_a ^ w_b;
            3'b110:  w_res = w_a | w_b;
            3'b111:  w_res = w_a & w_b;
            default: w_res = w_a;
        endcase
    end

    assign w_shift_step = r_left ? {r_acc[XLEN-2:0], 1'b0}
                                 : {r_arith & r_acc[XLEN-1], r_acc[XLEN-1:1]};
`ifdef ALU_MUL_EN
    assign w_mul_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept = bus.in_valid && w_ready;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (!w_accept) begin
                    w_state_nxt = S_IDLE;
                end else if (w_is_mul) begin
                    w_state_nxt = S_MUL;
                end else if (w_is_shift && (w_shamt != '0)) begin
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_out     <= '0;
            r_illegal <= 1'b0;
            r_left    <= 1'b0;
            r_arith   <= 1'b0;
`ifdef ALU_MUL_EN
            r_mcand   <= '0;
            r_mplier  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            r_out     <= '0;
                            r_illegal <= 1'b1;
                        end
`ifdef ALU_MUL_EN
                        else if (w_is_mul) begin
                            r_acc    <= '0;
                            r_mcand  <= w_a;
                            r_mplier <= bus.in_r2;
                            r_cnt    <= CW'(XLEN);
                        end
`endif
                        else if (w_is_shift && (w_shamt != '0)) begin
                            r_acc   <= w_a;
                            r_cnt   <= {1'b0, w_shamt};
                            r_left  <= (w_funct3 == 3'b001);
                            r_arith <= w_funct7[5];
                        end else begin
                            r_out     <= w_res;
                            r_illegal <= 1'b0;
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_shift_step;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_out     <= w_shift_step;
                        r_illegal <= 1'b0;
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    r_acc    <= w_mul_sum;
                    r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_out     <= w_mul_sum;
                        r_illegal <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.out_ready   = w_ready;
    assign bus.out         = r_out;
    assign bus.out_illegal = r_illegal;
    assign bus.out_valid   = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed scoreboard bench for alu_seq at XLEN=8 (both
//               ALU_MUL_EN builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;
    logic in_clk   = 1'b0;
    logic in_rst_n = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        logic [7:0] out;
        logic       ill;
        int         due;
        string      tag;
    } exp_t;

    exp_t q[$];

    alu_seq_if #(.XLEN(8)) bus ();

    alu_seq #(.XLEN(8)) dut (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .bus      (bus)
    );

    always #5 in_clk = ~in_clk;
    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction

    // Called #1 after a rising edge; leaves time #1 after the accept edge.
    task automatic issue(input string tag, input logic [31:0] inst, input logic [7:0] r1,
                         input logic [7:0] r2, input logic [7:0] eo, input logic ei,
                         input int lat, input bit expect_result);
        exp_t e;
        check({tag, "_ready"}, {31'd0, bus.out_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_r1    = r1;
        bus.in_r2    = r2;
        @(posedge in_clk);
        #1;
        bus.in_valid = 1'b0;
        if (expect_result) begin
            e.out = eo;
            e.ill = ei;
            e.due = cyc + lat - 1;
            e.tag = tag;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge in_clk);
        repeat (2) @(posedge in_clk);
        #1;
        check("drain_empty", q.size(), 32'd0);
    endtask

    always @(negedge in_clk) begin
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.tag, "_out"}, {24'd0, bus.out}, {24'd0, e.out});
                check({e.tag, "_illegal"}, {31'd0, bus.out_illegal}, {31'd0, e.ill});
                check({e.tag, "_latency"}, cyc, e.due);
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_inst  = '0;
        bus.in_r1    = '0;
        bus.in_r2    = '0;
        #1 in_rst_n = 1'b0;
        #2;
        check("rst_out", {24'd0, bus.out}, 32'd0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_illegal", {31'd0, bus.out_illegal}, 32'd0);
        @(posedge in_clk);
        @(posedge in_clk);
        #1 in_rst_n = 1'b1;
        check("rst_ready", {31'd0, bus.out_ready}, 32'd1);

        // Back-to-back: ADDI issued in the DONE cycle of ADD
        issue("add",  rtype(7'h00, 3'b000), 8'h05, 8'h03, 8'h08, 1'b0, 1, 1'b1);
        issue("addi", itype(12'hFFF, 3'b000), 8'h08, 8'h55, 8'h07, 1'b0, 1, 1'b1);
        drain();

        issue("sub",  rtype(7'h20, 3'b000), 8'h03, 8'h05, 8'hFE, 1'b0, 1, 1'b1);
        issue("slt",  rtype(7'h00, 3'b010), 8'h80, 8'h01, 8'h01, 1'b0, 1, 1'b1);
        issue("sltu", rtype(7'h00, 3'b011), 8'h80, 8'h01, 8'h00, 1'b0, 1, 1'b1);
        issue("xori", itype(12'h0F0, 3'b100), 8'h3C, 8'h00, 8'hCC, 1'b0, 1, 1'b1);
        issue("or",   rtype(7'h00, 3'b110), 8'h30, 8'h0C, 8'h3C, 1'b0, 1, 1'b1);
        issue("andi", itype(12'h00F, 3'b111), 8'h5A, 8'h00, 8'h0A, 1'b0, 1, 1'b1);
        issue("sltiu", itype(12'hFFF, 3'b011), 8'h10, 8'h00, 8'h01, 1'b0, 1, 1'b1);
        drain();

        // SRAI by 3; an ADD pulse while busy must be dropped
        issue("srai3", itype({7'h20, 5'd3}, 3'b101), 8'h90, 8'h00, 8'hF2, 1'b0, 4, 1'b1);
        check("busy_ready", {31'd0, bus.out_ready}, 32'd0);
        bus.in_valid = 1'b1;
        bus.in_inst  = rtype(7'h00, 3'b000);
        bus.in_r1    = 8'h11;
        bus.in_r2    = 8'h22;
        @(posedge in_clk);
        #1 bus.in_valid = 1'b0;
        drain();

        issue("srai0", itype({7'h20, 5'd0}, 3'b101), 8'h90, 8'h00, 8'h90, 1'b0, 1, 1'b1);
        issue("slli1", itype({7'h00, 5'd1}, 3'b001), 8'h81, 8'h00, 8'h02, 1'b0, 2, 1'b1);
        drain();
        issue("srl4",  rtype(7'h00, 3'b101), 8'h81, 8'h0C, 8'h08, 1'b0, 5, 1'b1);
        drain();

        issue("ill_r",   rtype(7'h20, 3'b001), 8'h12, 8'h34, 8'h00, 1'b1, 1, 1'b1);
        issue("add_ok",  rtype(7'h00, 3'b000), 8'h01, 8'h01, 8'h02, 1'b0, 1, 1'b1);
        issue("ill_slli", itype({7'h20, 5'd1}, 3'b001), 8'h12, 8'h00, 8'h00, 1'b1, 1, 1'b1);
        issue("ill_op",  32'h0000_007F, 8'h12, 8'h34, 8'h00, 1'b1, 1, 1'b1);
        issue("ill_div", rtype(7'h01, 3'b100), 8'h12, 8'h34, 8'h00, 1'b1, 1, 1'b1);
        drain();

`ifdef ALU_MUL_EN
        issue("mul", rtype(7'h01, 3'b000), 8'h0D, 8'h0B, 8'h8F, 1'b0, 9, 1'b1);
`else
        issue("mul_off", rtype(7'h01, 3'b000), 8'h0D, 8'h0B, 8'h00, 1'b1, 1, 1'b1);
`endif
        drain();

        // Reset two cycles into SRL by 7: aborted, no result ever appears
        issue("pre_rst", rtype(7'h00, 3'b000), 8'h40, 8'h05, 8'h45, 1'b0, 1, 1'b1);
        drain();
        issue("srl7", rtype(7'h00, 3'b101), 8'hFF, 8'h07, 8'h00, 1'b0, 8, 1'b0);
        @(posedge in_clk);
        @(posedge in_clk);
        #2 in_rst_n = 1'b0;
        #1;
        check("abort_out", {24'd0, bus.out}, 32'd0);
        check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_illegal", {31'd0, bus.out_illegal}, 32'd0);
        @(posedge in_clk);
        #1 in_rst_n = 1'b1;
        @(negedge in_clk);
        check("post_rst_ready", {31'd0, bus.out_ready}, 32'd1);
        repeat (12) @(posedge in_clk);
        #1;
        issue("add_after", rtype(7'h00, 3'b000), 8'h10, 8'h20, 8'h30, 1'b0, 1, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the combinational datapath ALU. It executes the full RV32I integer register-register and register-immediate ALU subsets at configurable width XLEN, and optionally the MUL instruction. It sits between register-file read and write-back. A valid/ready handshake on the issue side allows iterative operations (shifts, multiply) to hold off the next instruction.

## Interface
- XLEN, 8: datapath width. Must be a power of two, 4..32.
- in_clk  input  1  rising-edge clock
- in_rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  issue request; operands and instruction valid
- out_ready  output  1  block can accept an issue this cycle
- in_r1  input  XLEN  rs1 operand
- in_r2  input  XLEN  rs2 operand (ignored for I-type)
- in_inst  input  32  RISC-V instruction word
- out  output  XLEN  result register
- out_valid  output  1  one-cycle pulse, result on `out` is new
- out_illegal  output  1  qualifies `out_valid`: encoding not supported

## Operation
- Field decode:
  - funct7 = inst[31:25], funct3 = inst[14:12], opcode = inst[6:0]
  - imm = inst[31:20], sign-extended to XLEN; if XLEN < 12, truncated to imm[XLEN-1:0]
- R-type (opcode 0110011): ADD/SUB (funct7 0000000/0100000, funct3 000), SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101 (funct7 0000000/0100000), OR 110, AND 111.
- I-type (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI.
  - Shift-immediate requires inst[31:25] = 0000000 or 0100000 (SRAI only).
- Shift amount: low log2(XLEN) bits of r2 or imm.
- Arithmetic: modulo 2^XLEN. SLT compares signed XLEN-bit values, SLTU unsigned. SLT/SLTU results are zero-extended 0/1.
- Anything else is illegal: `out` = 0, `out_illegal` = 1, single-cycle latency.
- FSM states: IDLE, SHIFT, MUL, DONE.
  - IDLE/DONE with accept (in_valid & out_ready):
    - simple op or illegal → DONE, result registered
    - shift with shamt ≠ 0 → SHIFT, counter = shamt
    - shift with shamt = 0 → DONE, out = operand
    - MUL → MUL
  - IDLE/DONE without accept: DONE → IDLE.
  - SHIFT: one bit position per cycle (arithmetic fill for SRA/SRAI); counter hits 1 → DONE.
  - MUL: shift-add, one multiplier bit per cycle, XLEN cycles → DONE; low XLEN bits of product kept.
  - DONE: `out_valid` = 1 for exactly that cycle.
- out_ready = (state == IDLE) || (state == DONE). Low in SHIFT and MUL; in_valid there is ignored with no side effect.
- Operands and instruction are captured only at accept; later input changes have no effect.
- `out` and `out_illegal` hold their last values until the next DONE.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE
  - out = 0, out_valid = 0, out_illegal = 0
  - out_ready = 1 once in_rst_n deasserts
  - counters and internal operands cleared
- Reset mid-SHIFT/MUL aborts the operation; no `out_valid` is ever produced for it.
- Accept at edge k:
  - simple/illegal: out_valid high in cycle k+1
  - shift: cycle k+1+shamt
  - MUL: cycle k+1+XLEN
- Back-to-back: accept during DONE gives throughput of one simple op per cycle.

## Configuration
- ALU_MUL_EN defined: MUL (opcode 0110011, funct7 0000001, funct3 000) executes in the MUL state.
- ALU_MUL_EN undefined: MUL state and multiplier hardware absent; any funct7 0000001 encoding is illegal, single-cycle.
- Other funct3 values with funct7 0000001 are illegal in both builds.

## Test plan
- XLEN=8, ADD r1=8'h05 r2=8'h03 → out=8'h08, out_valid in cycle after accept, out_illegal=0. Follow with ADDI imm=12'hFFF issued in the DONE cycle → out=8'h07 next cycle.
- SUB 8'h03−8'h05 → 8'hFE; SLT r1=8'h80 r2=8'h01 → 8'h01; SLTU same operands → 8'h00.
- SRAI r1=8'h90 shamt=3 → out=8'hF2 exactly 4 cycles after accept. out_ready=0 during SHIFT; an in_valid ADD pulse in that window is dropped. shamt=0 → out=8'h90 after 1 cycle.
- inst with funct7=0100000 funct3=001 opcode=0110011 → out=8'h00, out_illegal=1, 1-cycle latency.
- ALU_MUL_EN defined: MUL 8'h0D×8'h0B → 8'h8F, out_valid 9 cycles after accept. Undefined: same instruction → out=0, out_illegal=1 after 1 cycle.
- in_rst_n pulled low 2 cycles into a SRL by 7 → out/out_valid/out_illegal = 0 immediately; no out_valid after release; out_ready=1 on the first cycle after release.
